// File: rtl/care_pkg.sv
// ---------------------------------------------------------------------------
// care_pkg
//   Shared definitions for the care-action controller: action indices, the
//   menu FSM state encoding and small helpers for menu wrap and the
//   pseudo-random stat index fold.
// ---------------------------------------------------------------------------
package care_pkg;

  localparam int NUM_ACTIONS = 6;

  typedef enum logic [2:0] {
    ACT_FEED  = 3'd0,
    ACT_PLAY  = 3'd1,
    ACT_HEAL  = 3'd2,
    ACT_WASH  = 3'd3,
    ACT_SLEEP = 3'd4,
    ACT_TALK  = 3'd5
  } action_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BROWSE   = 2'd1,
    APPLY    = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

  // Advance the highlighted action, wrapping after the last one.
  function automatic logic [2:0] next_sel(input logic [2:0] sel);
    return (sel == 3'(NUM_ACTIONS - 1)) ? 3'd0 : sel + 3'd1;
  endfunction

  // Fold a 3-bit value 0..7 onto the stat range 0..5.
  function automatic logic [2:0] fold_random(input logic [2:0] l);
    return (l < 3'd6) ? l : l - 3'd6;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Two-flop synchroniser, level debouncer and rising-edge detector for one
//   raw push-button.
//   Ports:
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     btn_raw_i  raw asynchronous button level (active-high)
//     press_o    one-cycle pulse on the debounced 0->1 transition
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter tracks how many consecutive samples disagree with the
  // accepted level; the level flips on the DEBOUNCE_CYCLES-th one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their inputs from the same clock edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/care_action_ctrl.sv
// ---------------------------------------------------------------------------
// care_action_ctrl
//   Turns three raw push-buttons into a menu-driven care action and emits
//   DOSE one-cycle one-hot pulses on care_pulse for the chosen action. Also
//   produces a pseudo-random stat index 0..5 from a 16-bit LFSR.
//   Ports:
//     clk, rst_n     27 MHz clock, asynchronous active-low reset
//     btn_next_raw   raw button: advance the highlighted action
//     btn_sel_raw    raw button: open the menu / apply the highlighted action
//     btn_back_raw   raw button: leave the menu
//     care_pulse     one-hot action pulses (bits 7:6 always 0)
//     random         pseudo-random stat index, 0..5
//     menu_sel       currently highlighted action, 0..5
//     menu_active    high in BROWSE, APPLY and COOLDOWN
//     busy           high in APPLY and COOLDOWN
// ---------------------------------------------------------------------------
module care_action_ctrl
  import care_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES     = 270_000,
  parameter int          MENU_TIMEOUT_CYCLES = 270_000_000,
  parameter int          COOLDOWN_CYCLES     = 27_000_000,
  parameter int          DOSE                = 2,
  parameter int          PULSE_GAP           = 4,
  parameter logic [15:0] LFSR_SEED           = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next_raw,
  input  logic       btn_sel_raw,
  input  logic       btn_back_raw,
  output logic [7:0] care_pulse,
  output logic [2:0] random,
  output logic [2:0] menu_sel,
  output logic       menu_active,
  output logic       busy
);

  // One shared timer serves the menu timeout, the pulse period and the
  // cooldown, so it is sized for the largest of them.
  localparam int TMAX_A = (MENU_TIMEOUT_CYCLES > COOLDOWN_CYCLES) ? MENU_TIMEOUT_CYCLES
                                                                  : COOLDOWN_CYCLES;
  localparam int TMAX   = (TMAX_A > PULSE_GAP + 1) ? TMAX_A : PULSE_GAP + 1;
  localparam int TW     = $clog2(TMAX + 1);

  // ---------------- button front ends ----------------
  logic p_next, p_sel, p_back;
  logic ev_next, ev_sel, ev_back;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst_n(rst_n), .btn_raw_i(btn_next_raw), .press_o(p_next)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
    .clk(clk), .rst_n(rst_n), .btn_raw_i(btn_sel_raw), .press_o(p_sel)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back (
    .clk(clk), .rst_n(rst_n), .btn_raw_i(btn_back_raw), .press_o(p_back)
  );

  // Same-cycle presses resolve back > sel > next; the losers are dropped.
  assign ev_back = p_back;
  assign ev_sel  = p_sel & ~p_back;
  assign ev_next = p_next & ~p_back & ~p_sel;

  // ---------------- menu FSM ----------------
  state_e        state_q, state_d;
  logic [2:0]    menu_sel_q, menu_sel_d;
  logic [2:0]    action_q, action_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    dose_q, dose_d;
  logic [7:0]    pulse_q, pulse_d;
  logic          menu_active_q, busy_q;

  always_comb begin
    state_d    = state_q;
    menu_sel_d = menu_sel_q;
    action_d   = action_q;
    tmr_d      = tmr_q;
    dose_d     = dose_q;
    pulse_d    = '0;

    case (state_q)
      IDLE: begin
        if (ev_sel || ev_next) begin
          state_d = BROWSE;
          tmr_d   = '0;
        end
      end

      BROWSE: begin
        tmr_d = tmr_q + 1'b1;
        // A press in the same cycle as the timeout wins and restarts it.
        if (ev_back) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (ev_sel) begin
          state_d  = APPLY;
          action_d = menu_sel_q;
          tmr_d    = '0;
          dose_d   = '0;
        end else if (ev_next) begin
          menu_sel_d = next_sel(menu_sel_q);
          tmr_d      = '0;
        end else if (tmr_q == TW'(MENU_TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      end

      APPLY: begin
        // Each pulse period is 1 high cycle plus PULSE_GAP low cycles;
        // the timer phase 0 launches the registered pulse.
        if (tmr_q == '0) pulse_d = 8'd1 << action_q;
        if (tmr_q == TW'(PULSE_GAP)) begin
          tmr_d = '0;
          if (dose_q == 4'(DOSE - 1)) begin
            state_d = COOLDOWN;
            dose_d  = '0;
          end else begin
            dose_d = dose_q + 4'd1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      COOLDOWN: begin
        if (tmr_q == TW'(COOLDOWN_CYCLES - 1)) begin
          state_d = BROWSE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      menu_sel_q    <= '0;
      action_q      <= '0;
      tmr_q         <= '0;
      dose_q        <= '0;
      pulse_q       <= '0;
      menu_active_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      menu_sel_q    <= menu_sel_d;
      action_q      <= action_d;
      tmr_q         <= tmr_d;
      dose_q        <= dose_d;
      pulse_q       <= pulse_d;
      // Status flags are registered from the next state so they line up
      // with state_q without a decode after the flops.
      menu_active_q <= (state_d != IDLE);
      busy_q        <= (state_d == APPLY) || (state_d == COOLDOWN);
    end
  end

  // ---------------- pseudo-random stat index ----------------
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  random_q;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right; the all-zero
  // lock-up state is escaped by reloading the seed.
  always_comb begin
    if (lfsr_q == 16'h0000) begin
      lfsr_d = LFSR_SEED;
    end else begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= LFSR_SEED;
      random_q <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      random_q <= fold_random(lfsr_q[2:0]);
    end
  end

  assign care_pulse  = pulse_q;
  assign random      = random_q;
  assign menu_sel    = menu_sel_q;
  assign menu_active = menu_active_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_care_action_ctrl.sv
// ---------------------------------------------------------------------------
// tb_care_action_ctrl
//   Self-checking bench for care_action_ctrl with short timing parameters.
//   Expected pulses are queued when an action is requested and a separate
//   monitor pops and compares them whenever care_pulse is non-zero.
// ---------------------------------------------------------------------------
module tb_care_action_ctrl;

  localparam int          DEB   = 4;
  localparam int          TMO   = 50;
  localparam int          CD    = 20;
  localparam int          DOSE  = 2;
  localparam int          GAP   = 4;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          HOLD  = DEB + 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_next_raw = 1'b0;
  logic       btn_sel_raw = 1'b0;
  logic       btn_back_raw = 1'b0;
  logic [7:0] care_pulse;
  logic [2:0] rnd;
  logic [2:0] menu_sel;
  logic       menu_active;
  logic       busy;

  care_action_ctrl #(
    .DEBOUNCE_CYCLES    (DEB),
    .MENU_TIMEOUT_CYCLES(TMO),
    .COOLDOWN_CYCLES    (CD),
    .DOSE               (DOSE),
    .PULSE_GAP          (GAP),
    .LFSR_SEED          (SEED)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_next_raw(btn_next_raw),
    .btn_sel_raw (btn_sel_raw),
    .btn_back_raw(btn_back_raw),
    .care_pulse  (care_pulse),
    .random      (rnd),
    .menu_sel    (menu_sel),
    .menu_active (menu_active),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard + monitor ----------------
  typedef struct packed {
    logic [7:0] val;
    bit         first;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   cyc = 0;
  int   last_pulse_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (care_pulse != 8'h00) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", care_pulse, 32'h0);
      end else begin
        sb_e = sb_q.pop_front();
        check("pulse_value", care_pulse, sb_e.val);
        if (!sb_e.first) check("pulse_spacing", cyc - last_pulse_cyc, GAP + 1);
      end
      last_pulse_cyc = cyc;
    end
  end

  // ---------------- reference model ----------------
  int model_sel = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return (l >> 1) | (16'(fb) << 15);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       btn_next_raw = v;
      1:       btn_sel_raw  = v;
      default: btn_back_raw = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    repeat (HOLD) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (HOLD) @(negedge clk);
  endtask

  // From BROWSE: n_next presses of next, then sel (optionally together with
  // next). Returns on the first sample back in BROWSE after the cooldown.
  task automatic do_action(input int n_next, input bit poke, input bit with_next);
    int wait_cnt;
    int busy_cnt;
    for (int i = 0; i < n_next; i++) begin
      press(0);
      model_sel = (model_sel + 1) % 6;
      check("menu_sel_next", menu_sel, model_sel);
    end
    btn_sel_raw = 1'b1;
    if (with_next) btn_next_raw = 1'b1;
    for (int d = 0; d < DOSE; d++) sb_q.push_back('{val: 8'(1 << model_sel), first: (d == 0)});
    wait_cnt = 0;
    while (!busy && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("busy_rise", busy, 1);
    busy_cnt = 0;
    while (busy && busy_cnt < 200) begin
      busy_cnt++;
      if (busy_cnt == 3) begin
        btn_sel_raw  = 1'b0;
        btn_next_raw = 1'b0;
      end
      // A next press landing in COOLDOWN must be discarded.
      if (poke && busy_cnt == 12) btn_next_raw = 1'b1;
      if (poke && busy_cnt == 22) btn_next_raw = 1'b0;
      @(negedge clk);
    end
    check("busy_len", busy_cnt, DOSE * (GAP + 1) + CD);
    check("menu_sel_after_action", menu_sel, model_sel);
    check("active_after_action", menu_active, 1);
  endtask

  // Counts samples with menu_active high starting at the current sample,
  // optionally raising next at sample raise_at.
  task automatic count_active(input int raise_at, output int cnt);
    cnt = 0;
    while (menu_active && cnt < 300) begin
      cnt++;
      if (cnt == raise_at) btn_next_raw = 1'b1;
      if (raise_at > 0 && cnt == raise_at + 10) btn_next_raw = 1'b0;
      @(negedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          cnt;
    int          bad;
    logic [5:0]  seen;
    logic [15:0] l;
    logic [15:0] v0, v1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_care_pulse", care_pulse, 0);
    check("rst_random", rnd, 0);
    check("rst_menu_sel", menu_sel, 0);
    check("rst_menu_active", menu_active, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Open menu, 3x next, apply -> two pulses of 8'h08, then BROWSE at 3
    press(1);
    check("idle_sel_active", menu_active, 1);
    check("idle_sel_menu_sel", menu_sel, 0);
    do_action(3, 1'b0, 1'b0);

    // Idle timeout: BROWSE lasts exactly TMO cycles
    count_active(0, cnt);
    check("timeout_len", cnt, TMO);
    check("timeout_idle", menu_active, 0);

    // Reopen keeps menu_sel, then wrap sequence
    press(1);
    check("reopen_menu_sel", menu_sel, model_sel);
    for (int i = 0; i < 9; i++) begin
      press(0);
      model_sel = (model_sel + 1) % 6;
      check("wrap_menu_sel", menu_sel, model_sel);
    end

    // Randomised actions with a discarded press during cooldown
    for (int i = 0; i < 4; i++) do_action(int'($urandom_range(0, 7)), 1'b1, 1'b0);

    // Press event in the last timeout cycle restarts the count
    do_action(int'($urandom_range(0, 5)), 1'b0, 1'b0);
    count_active(44, cnt);
    model_sel = (model_sel + 1) % 6;
    check("timeout_restart_len", cnt, 2 * TMO);
    check("timeout_restart_sel", menu_sel, model_sel);

    // Bouncing button yields exactly one press (IDLE -> BROWSE, no advance)
    for (int i = 0; i < 20; i++) begin
      btn_next_raw = ~btn_next_raw;
      repeat (2) @(negedge clk);
    end
    press(0);
    check("bounce_active", menu_active, 1);
    check("bounce_menu_sel", menu_sel, model_sel);

    // sel + next together -> APPLY of the current action only
    do_action(0, 1'b0, 1'b1);

    // back + sel together -> back wins
    btn_back_raw = 1'b1;
    btn_sel_raw  = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn_back_raw = 1'b0;
    btn_sel_raw  = 1'b0;
    repeat (HOLD) @(negedge clk);
    check("back_wins_active", menu_active, 0);
    check("back_wins_busy", busy, 0);

    // Reset between the first and second pulse
    press(1);
    btn_sel_raw = 1'b1;
    sb_q.push_back('{val: 8'(1 << model_sel), first: 1'b1});
    cnt = 0;
    while (care_pulse == 8'h00 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("first_pulse_seen", (care_pulse != 8'h00), 1);
    btn_sel_raw = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_care_pulse", care_pulse, 0);
    check("async_rst_menu_active", menu_active, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_menu_sel", menu_sel, 0);
    check("async_rst_random", rnd, 0);
    model_sel = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // random follows the LFSR from its seed, one registered stage behind
    l = SEED;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("lfsr_sequence", rnd, 32'(l[2:0] % 6));
      l = lfsr_step(l);
    end
    repeat (20) @(negedge clk);
    check("post_rst_idle", menu_active, 0);

    // Button held through reset -> one press DEB+2 cycles after release,
    // state change one cycle later
    btn_sel_raw = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (!menu_active && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("held_through_reset_latency", cnt, DEB + 3);
    btn_sel_raw = 1'b0;
    repeat (HOLD) @(negedge clk);
    check("held_through_reset_sel", menu_sel, 0);

    // Free-running random range and coverage
    bad  = 0;
    seen = '0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (rnd > 3'd5) bad++;
      else seen[rnd] = 1'b1;
    end
    check("random_out_of_range", bad, 0);
    check("random_all_values", seen, 6'h3F);

    // Zero LFSR is escaped by reloading the seed
    @(negedge clk);
    force dut.lfsr_q = 16'h0000;
    @(negedge clk);
    release dut.lfsr_q;
    #1 v0 = dut.lfsr_q;
    @(negedge clk);
    v1 = dut.lfsr_q;
    check("lfsr_zero_reload", (v0 == SEED) || (v1 == SEED), 1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
